// File: rtl/seq_div16_8_if.sv
// seq_div16_8_if: operand/result handshake bundle for the sequential divider.
// Ports (signals): in_valid/in_ready/dividend/divisor (request side),
//   out_valid/out_ready/quotient/remainder/div_by_zero (result side).
//   master = producer+consumer of the divider, slave = the divider itself.
interface seq_div16_8_if #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_div16_8.sv
// seq_div16_8: iterative restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), bus (seq_div16_8_if.slave).
// Optional macro DIV_ZERO_FAST_EN: divisor==0 skips CALC (IDLE -> DONE).
module seq_div16_8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_div16_8_if.slave  bus
);

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_DZ = 1'b1;
`else
    localparam bit FAST_DZ = 1'b0;
`endif

    localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DIVIDEND_W-1:0] rq;
    logic [DIVISOR_W-1:0]  rr;
    logic [DIVISOR_W-1:0]  dvsr;
    logic [DIVISOR_W-1:0]  dlo;
    logic                  dz;

    logic                  in_rdy;
    logic                  out_vld;
    logic [DIVIDEND_W-1:0] q_o;
    logic [DIVISOR_W-1:0]  r_o;
    logic                  dbz_o;

    // The partial remainder is always < divisor between steps, so it
    // is stored in DIVISOR_W bits; the shifted value needs one more bit
    // for the compare, and the difference fits back in DIVISOR_W bits.
    logic [DIVISOR_W:0]    r_sh;
    logic [DIVISOR_W-1:0]  r_sub;
    logic                  ge;
    logic [DIVIDEND_W-1:0] q_nx;
    logic [DIVISOR_W-1:0]  r_nx;

    always_comb begin
        r_sh  = {rr, rq[DIVIDEND_W-1]};
        ge    = (r_sh >= {1'b0, dvsr});
        r_sub = r_sh[DIVISOR_W-1:0] - dvsr;
        q_nx  = {rq[DIVIDEND_W-2:0], ge};
        r_nx  = ge ? r_sub : r_sh[DIVISOR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rq      <= '0;
            rr      <= '0;
            dvsr    <= '0;
            dlo     <= '0;
            dz      <= 1'b0;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
            q_o     <= '0;
            r_o     <= '0;
            dbz_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        rq     <= bus.dividend;
                        rr     <= '0;
                        dvsr   <= bus.divisor;
                        dlo    <= bus.dividend[DIVISOR_W-1:0];
                        dz     <= (bus.divisor == '0);
                        cnt    <= '0;
                        in_rdy <= 1'b0;
                        if (FAST_DZ && bus.divisor == '0) begin
                            state   <= DONE;
                            out_vld <= 1'b1;
                            q_o     <= '1;
                            r_o     <= bus.dividend[DIVISOR_W-1:0];
                            dbz_o   <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rq  <= q_nx;
                    rr  <= r_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state   <= DONE;
                        cnt     <= '0;
                        out_vld <= 1'b1;
                        // divisor 0 ran the loop only to keep timing
                        // uniform; its raw result is meaningless.
                        q_o     <= dz ? '1  : q_nx;
                        r_o     <= dz ? dlo : r_nx;
                        dbz_o   <= dz;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state   <= IDLE;
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    out_vld <= 1'b0;
                    in_rdy  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = out_vld;
    assign bus.quotient    = q_o;
    assign bus.remainder   = r_o;
    assign bus.div_by_zero = dbz_o;

    a_rdy_state: assert property (
        @(posedge clk) disable iff (rst)
        in_rdy == (state == IDLE)
    );

    a_vld_state: assert property (
        @(posedge clk) disable iff (rst)
        out_vld == (state == DONE)
    );

    a_hold: assert property (
        @(posedge clk) disable iff (rst)
        (out_vld && !bus.out_ready) |=>
            (out_vld && $stable(q_o) && $stable(r_o) && $stable(dbz_o))
    );

    a_rem_lt: assert property (
        @(posedge clk) disable iff (rst)
        (out_vld && !dbz_o) |-> (r_o < dvsr)
    );

endmodule
